// File: rtl/sv_trigger_pkg.sv
// sv_trigger_pkg
//   Shared types and default widths for the trigger scheduler.
//   - trig_mode_t  : encoding of the i_mode input (11 behaves as OFF)
//   - trig_state_t : scheduler FSM states
//   - CNT_W_DEF / PLEN_W_DEF : default counter widths
package sv_trigger_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned PLEN_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_EDGE    = 2'b01,
    MODE_FREERUN = 2'b10,
    MODE_OFF_ALT = 2'b11
  } trig_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    PULSE   = 2'b10,
    HOLDOFF = 2'b11
  } trig_state_t;

endpackage

// File: rtl/sv_trig_timer.sv
// sv_trig_timer
//   Loadable down-counter with an expire flag.
//   Ports:
//     clk_i      : clock
//     rst_ni     : async active-low reset
//     load_i     : load load_val_i (has priority over counting)
//     load_val_i : value to load, in cycles
//     en_i       : count enable
//     expire_o   : high in the last counted cycle (count == 1 while enabled)
//   After expiring the counter parks at zero until the next load.
module sv_trig_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/sv_trigger_ctrl.sv
// sv_trigger_ctrl
//   Trigger scheduler: shapes edge or free-run requests into pulses of a
//   programmed width, with holdoff between pulses, burst limit and drops
//   while the sensor is busy.
//   Ports:
//     i_clk, i_aresetn : clock, async active-low reset
//     i_trig           : synced trigger level (EDGE mode uses its rising edge)
//     i_mode           : 00 OFF, 01 EDGE, 10 FREERUN, 11 OFF
//     i_period         : FREERUN request spacing in cycles
//     i_pulse_len      : pulse high time in cycles (0 behaves as 1)
//     i_holdoff        : low cycles forced after each pulse
//     i_burst_len      : pulses per run, 0 = unlimited
//     i_start, i_stop  : single-cycle run control
//     i_sensor_busy    : requests seen while high are discarded
//     o_trigger        : shaped pulse (registered)
//     o_active         : run in progress
//     o_done           : single-cycle pulse when a run ends
//     o_pulse_cnt      : pulses issued this run (saturating)
//     o_drop_cnt       : discarded requests (only with TRIG_DROP_CNT_EN)
//     o_state          : current FSM state, for debug/observation
//   Build option: define TRIG_DROP_CNT_EN to add the o_drop_cnt counter.
//   Control protocol: i_start/i_stop are sampled every cycle as one-cycle
//   strobes; there is no back-pressure. i_start is honoured only in IDLE
//   with a non-OFF mode, and i_stop wins when both are high.
module sv_trigger_ctrl
  import sv_trigger_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PLEN_W = PLEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_aresetn,
  input  logic              i_trig,
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [PLEN_W-1:0] i_pulse_len,
  input  logic [CNT_W-1:0]  i_holdoff,
  input  logic [PLEN_W-1:0] i_burst_len,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sensor_busy,
  output logic              o_trigger,
  output logic              o_active,
  output logic              o_done,
  output logic [PLEN_W-1:0] o_pulse_cnt,
`ifdef TRIG_DROP_CNT_EN
  output logic [PLEN_W-1:0] o_drop_cnt,
`endif
  output trig_state_t       o_state
);

  trig_state_t       state_q, state_d;
  logic              trig_prev_q;
  logic              freerun_q;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  holdoff_q;
  logic [PLEN_W-1:0] plen_q;
  logic [PLEN_W-1:0] burst_q;
  logic [PLEN_W-1:0] pulse_cnt_q;
  logic              trigger_q;
  logic              done_q;
  logic              tick_pend_q;
  logic              stop_pend_q;

  trig_mode_t        mode_in;
  logic              start_ok;
  logic              trig_edge;
  logic              req;
  logic              burst_hit;
  logic              accept_start;
  logic              pulse_start;
  logic              consume;
  logic              pw_load;
  logic [CNT_W-1:0]  pw_val;
  logic              per_load;
  logic [CNT_W-1:0]  per_val;
  logic              pw_expire;
  logic              per_expire;

  assign mode_in   = trig_mode_t'(i_mode);
  assign start_ok  = i_start && !i_stop &&
                     ((mode_in == MODE_EDGE) || (mode_in == MODE_FREERUN));
  assign trig_edge = i_trig && !trig_prev_q;
  // A free-run tick that lands in PULSE/HOLDOFF is held in tick_pend_q and
  // served on the first ARMED cycle, which stretches the spacing.
  assign req       = freerun_q ? (per_expire || tick_pend_q) : trig_edge;
  assign burst_hit = (burst_q != '0) && (pulse_cnt_q == burst_q);

  // Pulse width and holdoff never overlap, so one timer serves both.
  sv_trig_timer #(.W(CNT_W)) u_pw_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_aresetn),
    .load_i     (pw_load),
    .load_val_i (pw_val),
    .en_i       ((state_q == PULSE) || (state_q == HOLDOFF)),
    .expire_o   (pw_expire)
  );

  // Reloaded whenever a free-run request is consumed (issued or dropped);
  // loaded with 1 at start so the first request falls in the first ARMED cycle.
  sv_trig_timer #(.W(CNT_W)) u_period_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_aresetn),
    .load_i     (per_load),
    .load_val_i (per_val),
    .en_i       ((state_q != IDLE) && freerun_q),
    .expire_o   (per_expire)
  );

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    pulse_start  = 1'b0;
    consume      = 1'b0;
    pw_load      = 1'b0;
    pw_val       = '0;
    per_load     = 1'b0;
    per_val      = period_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d      = ARMED;
          accept_start = 1'b1;
          per_load     = 1'b1;
          per_val      = CNT_W'(1);
        end
      end
      ARMED: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (req) begin
          consume  = 1'b1;
          per_load = freerun_q;
          if (!i_sensor_busy) begin
            state_d     = PULSE;
            pulse_start = 1'b1;
            pw_load     = 1'b1;
            pw_val      = CNT_W'(plen_q);
          end
        end
      end
      PULSE: begin
        // A stop during the pulse is remembered so the pulse keeps full width.
        if (pw_expire) begin
          if (stop_pend_q || i_stop || burst_hit) begin
            state_d = IDLE;
          end else if (holdoff_q != '0) begin
            state_d = HOLDOFF;
            pw_load = 1'b1;
            pw_val  = holdoff_q;
          end else begin
            state_d = ARMED;
          end
        end
      end
      HOLDOFF: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (pw_expire) begin
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      freerun_q   <= 1'b0;
      period_q    <= '0;
      holdoff_q   <= '0;
      plen_q      <= '0;
      burst_q     <= '0;
      pulse_cnt_q <= '0;
      trigger_q   <= 1'b0;
      done_q      <= 1'b0;
      tick_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= i_trig;
      trigger_q   <= (state_d == PULSE);
      done_q      <= (state_q != IDLE) && (state_d == IDLE);

      if (accept_start) begin
        freerun_q <= (mode_in == MODE_FREERUN);
        period_q  <= (i_period == '0) ? CNT_W'(1) : i_period;
        plen_q    <= (i_pulse_len == '0) ? PLEN_W'(1) : i_pulse_len;
        holdoff_q <= i_holdoff;
        burst_q   <= i_burst_len;
      end

      if (accept_start) begin
        pulse_cnt_q <= '0;
      end else if (pulse_start && (pulse_cnt_q != '1)) begin
        pulse_cnt_q <= pulse_cnt_q + 1'b1;
      end

      if ((state_d == IDLE) || accept_start || consume) begin
        tick_pend_q <= 1'b0;
      end else if (per_expire && (state_q != ARMED)) begin
        tick_pend_q <= 1'b1;
      end

      if (state_d == IDLE) begin
        stop_pend_q <= 1'b0;
      end else if (i_stop && (state_q == PULSE)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

`ifdef TRIG_DROP_CNT_EN
  logic              drop;
  logic [PLEN_W-1:0] drop_cnt_q;

  // Drops are only counted while the run continues; a request coinciding
  // with the run ending is simply lost with the run.
  always_comb begin
    drop = 1'b0;
    if (state_d != IDLE) begin
      if ((state_q == ARMED) && req && i_sensor_busy) begin
        drop = 1'b1;
      end
      if (!freerun_q && trig_edge && ((state_q == PULSE) || (state_q == HOLDOFF))) begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      drop_cnt_q <= '0;
    end else if (accept_start) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  assign o_trigger   = trigger_q;
  assign o_active    = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_pulse_cnt = pulse_cnt_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_sv_trigger_ctrl.sv
`timescale 1ns/1ps
module tb_sv_trigger_ctrl;
  import sv_trigger_pkg::*;

  localparam int CNT_W  = 32;
  localparam int PLEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              i_trig = 1'b0;
  logic [1:0]        i_mode = 2'b00;
  logic [CNT_W-1:0]  i_period = '0;
  logic [PLEN_W-1:0] i_pulse_len = '0;
  logic [CNT_W-1:0]  i_holdoff = '0;
  logic [PLEN_W-1:0] i_burst_len = '0;
  logic              i_start = 1'b0;
  logic              i_stop = 1'b0;
  logic              i_sensor_busy = 1'b0;
  logic              o_trigger;
  logic              o_active;
  logic              o_done;
  logic [PLEN_W-1:0] o_pulse_cnt;
`ifdef TRIG_DROP_CNT_EN
  logic [PLEN_W-1:0] o_drop_cnt;
`endif
  trig_state_t       o_state;

  sv_trigger_ctrl #(.CNT_W(CNT_W), .PLEN_W(PLEN_W)) dut (
    .i_clk         (clk),
    .i_aresetn     (rst_n),
    .i_trig        (i_trig),
    .i_mode        (i_mode),
    .i_period      (i_period),
    .i_pulse_len   (i_pulse_len),
    .i_holdoff     (i_holdoff),
    .i_burst_len   (i_burst_len),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_sensor_busy (i_sensor_busy),
    .o_trigger     (o_trigger),
    .o_active      (o_active),
    .o_done        (o_done),
    .o_pulse_cnt   (o_pulse_cnt),
`ifdef TRIG_DROP_CNT_EN
    .o_drop_cnt    (o_drop_cnt),
`endif
    .o_state       (o_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_start_q[$];
  logic [31:0] exp_cnt_q[$];
  logic [31:0] exp_len_q[$];
  logic [31:0] exp_done_q[$];
  bit st_trig [256];
  bit st_busy [256];
  bit mon_en = 1'b1;
  bit mon_prev = 1'b0;
  int cur_start = 0;
  int cur_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic clear_stim();
    for (int t = 0; t < 256; t++) begin
      st_trig[t] = 1'b0;
      st_busy[t] = 1'b0;
    end
  endtask

  // Reference model. Works on relative cycles t (t=0 is the start cycle).
  // "ready" is the first cycle a request may be accepted; a pulse requested
  // in cycle t occupies t+1..t+plen and the next request may be honoured
  // holdoff+1 cycles after the pulse ends. Free-run requests recur period
  // cycles after the previous one was served or dropped.
  task automatic model(input int base, input bit free, input int period, input int plen,
                       input int holdoff, input int burst, input int stop_t,
                       output int npulse, output int drops);
    int ready;
    int pend;
    int next_tick;
    bit stopreq;
    bit req;
    ready = 1; pend = 0; next_tick = 1; stopreq = 1'b0;
    npulse = 0; drops = 0;
    for (int t = 1; t < 250; t++) begin
      if (t == stop_t) begin
        if (t <= pend) stopreq = 1'b1;
        else begin
          exp_done_q.push_back(32'(base + t + 1));
          return;
        end
      end
      if (t == pend && (stopreq || (burst != 0 && npulse == burst))) begin
        exp_done_q.push_back(32'(base + t + 1));
        return;
      end
      if (t == pend) ready = t + holdoff + 1;
      req = free ? (t >= next_tick) : (st_trig[t] && !st_trig[t-1]);
      if (t < ready) begin
        if (!free && req) drops++;
      end else if (req) begin
        if (free) next_tick = t + period;
        if (st_busy[t]) drops++;
        else begin
          npulse++;
          pend = t + plen;
          ready = pend + 1;
          exp_start_q.push_back(32'(base + t + 1));
          exp_cnt_q.push_back(32'(npulse));
          exp_len_q.push_back(32'(plen));
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_trigger && !mon_prev) begin
          if (exp_start_q.size() == 0) flag_unexpected("pulse_unexpected");
          else begin
            check("pulse_start", 32'(cyc), exp_start_q.pop_front());
            check("pulse_cnt", 32'(o_pulse_cnt), exp_cnt_q.pop_front());
            cur_start = cyc;
            cur_len = int'(exp_len_q.pop_front());
          end
        end
        if (!o_trigger && mon_prev) check("pulse_width", 32'(cyc - cur_start), 32'(cur_len));
        if (o_done) begin
          if (exp_done_q.size() == 0) flag_unexpected("done_unexpected");
          else check("done_cycle", 32'(cyc), exp_done_q.pop_front());
          check("done_inactive", 32'(o_active), 32'd0);
        end
      end
      mon_prev = o_trigger;
    end
  end

  // ---------------- driver ----------------
  task automatic run_scen(input bit free, input int period, input int plen, input int holdoff,
                          input int burst, input int stop_t);
    int base;
    int np;
    int nd;
    int n;
    @(negedge clk);
    base = cyc;
    i_mode = free ? 2'b10 : 2'b01;
    i_period = CNT_W'(period);
    i_pulse_len = PLEN_W'(plen);
    i_holdoff = CNT_W'(holdoff);
    i_burst_len = PLEN_W'(burst);
    i_start = 1'b1; i_stop = 1'b0; i_trig = 1'b0; i_sensor_busy = 1'b0;
    model(base, free, (period == 0) ? 1 : period, (plen == 0) ? 1 : plen, holdoff, burst,
          stop_t, np, nd);
    for (int t = 1; t <= stop_t; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_trig = st_trig[t];
      i_sensor_busy = st_busy[t];
      i_stop = (t == stop_t);
      // config inputs wander mid-run; the latched values must be used
      i_mode = 2'($urandom_range(3, 0));
      i_period = CNT_W'($urandom_range(40, 0));
      i_pulse_len = PLEN_W'($urandom_range(40, 0));
      i_holdoff = CNT_W'($urandom_range(40, 0));
      i_burst_len = PLEN_W'($urandom_range(9, 0));
    end
    @(negedge clk);
    i_trig = 1'b0; i_sensor_busy = 1'b0; i_stop = 1'b0;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_start_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("done_drained", 32'(exp_done_q.size()), 32'd0);
    check("pulses_drained", 32'(exp_start_q.size()), 32'd0);
    check("active_after_run", 32'(o_active), 32'd0);
    check("pulse_cnt_after_run", 32'(o_pulse_cnt), 32'(np));
`ifdef TRIG_DROP_CNT_EN
    check("drop_cnt", 32'(o_drop_cnt), 32'(nd));
`endif
    exp_start_q.delete(); exp_cnt_q.delete(); exp_len_q.delete(); exp_done_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_trigger", 32'(o_trigger), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_pulse_cnt", 32'(o_pulse_cnt), 32'd0);
    check("rst_state", 32'(o_state), 32'(IDLE));
`ifdef TRIG_DROP_CNT_EN
    check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // edge, width 4, rise at cycle 10
    clear_stim();
    for (int t = 10; t < 40; t++) st_trig[t] = 1'b1;
    run_scen(1'b0, 1, 4, 0, 0, 40);

    // free-run burst of 3 spaced 10 apart
    clear_stim();
    run_scen(1'b1, 10, 2, 0, 3, 60);

    // holdoff swallows edges arriving every 3 cycles
    clear_stim();
    for (int t = 3; t < 46; t++) st_trig[t] = (t % 3 == 0);
    run_scen(1'b0, 1, 2, 5, 0, 50);

    // busy during the second free-run tick
    clear_stim();
    st_busy[11] = 1'b1;
    run_scen(1'b1, 10, 2, 0, 0, 45);

    // stop in the third cycle of an 8-cycle pulse
    clear_stim();
    for (int t = 5; t < 20; t++) st_trig[t] = 1'b1;
    run_scen(1'b0, 1, 8, 3, 0, 8);

    // free-run period shorter than pulse + holdoff
    clear_stim();
    run_scen(1'b1, 3, 4, 2, 0, 40);

    // pulse_len 0 behaves as 1
    clear_stim();
    st_trig[4] = 1'b1;
    run_scen(1'b0, 1, 0, 0, 0, 12);

    // randomized runs
    for (int k = 0; k < 24; k++) begin
      int stop_t;
      clear_stim();
      stop_t = $urandom_range(100, 30);
      for (int t = 1; t <= stop_t; t++) begin
        st_trig[t] = ($urandom_range(2, 0) == 0);
        st_busy[t] = ($urandom_range(5, 0) == 0);
      end
      run_scen(1'($urandom_range(1, 0)), $urandom_range(15, 1), $urandom_range(6, 0),
               $urandom_range(5, 0), $urandom_range(4, 0), stop_t);
    end

    // start and stop together in IDLE
    @(negedge clk);
    i_mode = 2'b01; i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_idle_active", 32'(o_active), 32'd0);
    check("start_stop_idle_state", 32'(o_state), 32'(IDLE));

    // start with an OFF mode is ignored
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      i_mode = (m == 0) ? 2'b00 : 2'b11; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("start_off_mode", 32'(o_active), 32'd0);
    end

    // async reset in the middle of a pulse
    @(negedge clk);
    mon_en = 1'b0;
    i_mode = 2'b01; i_pulse_len = 16'd20; i_holdoff = '0; i_burst_len = '0;
    i_trig = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_trig = 1'b1;
    repeat (5) @(negedge clk);
    check("trigger_before_reset", 32'(o_trigger), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("trigger_async_reset", 32'(o_trigger), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; i_trig = 1'b0;
    @(negedge clk);
    check("active_after_reset", 32'(o_active), 32'd0);
    check("pulse_cnt_after_reset", 32'(o_pulse_cnt), 32'd0);
    check("done_after_reset", 32'(o_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
